// File: rtl/gprf_pkg.sv
// Shared constants and the writeback entry type for the GPRF writeback arbiter.
package gprf_pkg;

  localparam int GPRF_DEPTH = 32;
  localparam int GPRF_WIDTH = 32;

  function automatic int idx_w(input int depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic [idx_w(GPRF_DEPTH)-1:0] idx;
    logic [GPRF_WIDTH-1:0]        data;
  } wb_entry_t;

endpackage

// File: rtl/gprf_wb_arb_if.sv
// Result-source handshake plus the GPRF write port, bundled for the arbiter.
interface gprf_wb_arb_if
  import gprf_pkg::*;
#(
  parameter int NSRC  = 3,
  parameter int DEPTH = GPRF_DEPTH,
  parameter int WIDTH = GPRF_WIDTH,
  localparam int IW   = idx_w(DEPTH)
);

  logic [NSRC-1:0]  src_valid;
  logic [NSRC-1:0]  src_ready;
  logic [IW-1:0]    src_idx  [NSRC];
  logic [WIDTH-1:0] src_data [NSRC];
  logic             hold;
  logic             wen;
  logic [IW-1:0]    widx;
  logic [WIDTH-1:0] wdata;
  logic             idle;

  modport master (
    output src_valid, src_idx, src_data, hold,
    input  src_ready, wen, widx, wdata, idle
  );

  modport slave (
    input  src_valid, src_idx, src_data, hold,
    output src_ready, wen, widx, wdata, idle
  );

endinterface

// File: rtl/wb_fifo.sv
// Small circular FIFO holding pending writeback entries for one result source.
module wb_fifo
  import gprf_pkg::*;
#(
  parameter int  BUFD = 2,
  parameter type T    = wb_entry_t,
  localparam int AW   = $clog2(BUFD),
  localparam int CW   = $clog2(BUFD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  T              din,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count
);

  T              mem_q [BUFD];
  T              mem_d [BUFD];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;

  // Pointers wrap naturally because BUFD is a power of two.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + 1'b1;
    end
    if (pop) begin
      rd_d = rd_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '{default: '0};
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_q];
  assign count = count_q;

endmodule

// File: rtl/gprf_wb_arb.sv
// Round-robin writeback arbiter: per-source FIFOs feeding one registered GPRF write port.
module gprf_wb_arb
  import gprf_pkg::*;
#(
  parameter int  NSRC    = 3,
  parameter int  DEPTH   = GPRF_DEPTH,
  parameter int  WIDTH   = GPRF_WIDTH,
  parameter int  BUFD    = 2,
  parameter bit  R0_IS_0 = 1'b1,
  localparam int IW      = idx_w(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  gprf_wb_arb_if.slave bus
);

  localparam int PW = (NSRC > 1) ? $clog2(NSRC) : 1;
  localparam int CW = $clog2(BUFD + 1);

  typedef struct packed {
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t           heads [NSRC];
  entry_t           din   [NSRC];
  logic [CW-1:0]    cnt   [NSRC];
  logic [NSRC-1:0]  push, pop;
  logic             grant;
  logic [PW-1:0]    winner;
  entry_t           win_e;
  int               cand;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             wen_q, wen_d;
  logic [IW-1:0]    widx_q, widx_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;

  // Ready comes only from registered counts, never from a same-cycle pop.
  always_comb begin
    bus.src_ready = '0;
    push          = '0;
    for (int s = 0; s < NSRC; s++) begin
      bus.src_ready[s] = cnt[s] < CW'(BUFD);
      push[s]          = bus.src_valid[s] && (cnt[s] < CW'(BUFD));
      din[s]           = '{idx: bus.src_idx[s], data: bus.src_data[s]};
    end
  end

  for (genvar s = 0; s < NSRC; s++) begin : g_src
    wb_fifo #(.BUFD(BUFD), .T(entry_t)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[s]),
      .din   (din[s]),
      .pop   (pop[s]),
      .head  (heads[s]),
      .count (cnt[s])
    );
  end

  // Scan from the farthest candidate back to rr_ptr so the nearest one wins last.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr_q) + k) % NSRC;
      if (!bus.hold && cnt[cand] != '0) begin
        grant  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
    win_e = heads[winner];
    pop   = '0;
    if (grant) begin
      pop[winner] = 1'b1;
    end
  end

  // A write to R0 still consumes its slot and moves the pointer, it just never reaches the file.
  always_comb begin
    rr_ptr_d = grant ? PW'((int'(winner) + 1) % NSRC) : rr_ptr_q;
    wen_d    = grant && !(R0_IS_0 && win_e.idx == '0);
    widx_d   = grant ? win_e.idx  : widx_q;
    wdata_d  = grant ? win_e.data : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      wen_q    <= 1'b0;
      widx_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wen_q    <= wen_d;
      widx_q   <= widx_d;
      wdata_q  <= wdata_d;
    end
  end

  always_comb begin
    bus.wen   = wen_q;
    bus.widx  = widx_q;
    bus.wdata = wdata_q;
    bus.idle  = !wen_q;
    for (int s = 0; s < NSRC; s++) begin
      if (cnt[s] != '0) begin
        bus.idle = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_gprf_wb_arb.sv
// Scoreboard bench for gprf_wb_arb: expected writes are queued at acceptance and checked at wen.
module tb_gprf_wb_arb;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
  } tb_entry_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tb_entry_t exp_q [$];
  tb_entry_t sq [3][$];
  tb_entry_t got;

  gprf_wb_arb_if #(.NSRC(3), .DEPTH(32), .WIDTH(32)) bus ();

  gprf_wb_arb #(
    .NSRC(3), .DEPTH(32), .WIDTH(32), .BUFD(2), .R0_IS_0(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic [4:0] idx, input logic [31:0] data);
    bus.src_idx[s]  = idx;
    bus.src_data[s] = data;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.src_valid = '0;
    bus.hold      = 1'b0;
    for (int s = 0; s < 3; s++) begin
      set_src(s, 5'd0, 32'd0);
      sq[s].delete();
    end
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    do_reset();
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen got %b want 0", bus.wen); end
    checks++; if (bus.widx !== 5'd0) begin errors++; $display("[TB] FAIL reset_widx got %0h want 0", bus.widx); end
    checks++; if (bus.wdata !== 32'd0) begin errors++; $display("[TB] FAIL reset_wdata got %0h want 0", bus.wdata); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL reset_idle got %b want 1", bus.idle); end
    checks++; if (bus.src_ready !== 3'b111) begin errors++; $display("[TB] FAIL reset_ready got %b want 111", bus.src_ready); end
  endtask

  task automatic test_single();
    $display("[TB] test_single");
    set_src(0, 5'd5, 32'hDEADBEEF);
    bus.src_valid = 3'b001;
    exp_q.push_back('{idx: 5'd5, data: 32'hDEADBEEF});
    tick();
    bus.src_valid = '0;
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL single_early_wen got %b want 0", bus.wen); end
    checks++; if (bus.idle !== 1'b0) begin errors++; $display("[TB] FAIL single_busy_idle got %b want 0", bus.idle); end
    tick();
    checks++;
    if (bus.wen !== 1'b1 || exp_q.size() == 0) begin
      errors++; $display("[TB] FAIL single_wen got %b want 1", bus.wen);
    end else begin
      got = '{idx: bus.widx, data: bus.wdata};
      if (got !== exp_q.pop_front()) begin
        errors++; $display("[TB] FAIL single_write got idx %0d data %0h want idx 5 data deadbeef", bus.widx, bus.wdata);
      end
    end
    tick();
    checks++; if (bus.wen !== 1'b0 || bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL single_idle got wen %b idle %b want wen 0 idle 1", bus.wen, bus.idle); end
  endtask

  task automatic test_all_sources();
    $display("[TB] test_all_sources");
    do_reset();
    for (int s = 0; s < 3; s++) begin
      set_src(s, 5'(s + 1), 32'h100 + 32'(s));
      exp_q.push_back('{idx: 5'(s + 1), data: 32'h100 + 32'(s)});
    end
    bus.src_valid = 3'b111;
    tick();
    bus.src_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.wen !== 1'b1 || exp_q.size() == 0) begin
        errors++; $display("[TB] FAIL all_wen_%0d got %b want 1", i, bus.wen);
      end else begin
        got = '{idx: bus.widx, data: bus.wdata};
        if (got !== exp_q[0]) begin
          errors++; $display("[TB] FAIL all_write_%0d got idx %0d data %0h want idx %0d data %0h",
                             i, bus.widx, bus.wdata, exp_q[0].idx, exp_q[0].data);
        end
        void'(exp_q.pop_front());
      end
    end
    // With the pointer back at 0, source 0 must beat source 2.
    set_src(0, 5'd20, 32'hA0);
    set_src(2, 5'd22, 32'hA2);
    exp_q.push_back('{idx: 5'd20, data: 32'hA0});
    exp_q.push_back('{idx: 5'd22, data: 32'hA2});
    bus.src_valid = 3'b101;
    tick();
    bus.src_valid = '0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      got = '{idx: bus.widx, data: bus.wdata};
      if (bus.wen !== 1'b1 || exp_q.size() == 0 || got !== exp_q[0]) begin
        errors++; $display("[TB] FAIL rr_wrap_%0d got wen %b idx %0d want idx %0d", i, bus.wen, bus.widx, (i == 0) ? 20 : 22);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_back_to_back();
    int nwr;
    bit pending;
    bit acc;
    $display("[TB] test_back_to_back");
    do_reset();
    bus.hold = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_src(1, 5'(7 + i), 32'hB000 + 32'(i));
      bus.src_valid = 3'b010;
      checks++; if (bus.src_ready[1] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_%0d got 0 want 1", i); end
      exp_q.push_back('{idx: 5'(7 + i), data: 32'hB000 + 32'(i)});
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      set_src(1, 5'd31, 32'hBAD0 + 32'(i));
      checks++; if (bus.src_ready[1] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_full_ready got 1 want 0"); end
      tick();
      checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL b2b_hold_wen got 1 want 0"); end
    end
    bus.hold = 1'b0;
    set_src(1, 5'd9, 32'hB002);
    pending = 1'b1;
    nwr     = 0;
    for (int c = 0; c < 12; c++) begin
      acc = pending && bus.src_ready[1];
      if (acc) exp_q.push_back('{idx: 5'd9, data: 32'hB002});
      tick();
      if (acc) begin
        bus.src_valid = '0;
        pending       = 1'b0;
      end
      if (bus.wen === 1'b1) begin
        nwr++;
        checks++;
        got = '{idx: bus.widx, data: bus.wdata};
        if (exp_q.size() == 0 || got !== exp_q[0]) begin
          errors++; $display("[TB] FAIL b2b_write_%0d got idx %0d data %0h", nwr, bus.widx, bus.wdata);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
    end
    checks++; if (nwr != 3 || pending) begin errors++; $display("[TB] FAIL b2b_count got %0d writes want 3", nwr); end
  endtask

  task automatic test_r0_discard();
    $display("[TB] test_r0_discard");
    do_reset();
    set_src(0, 5'd0, 32'h1234);
    bus.src_valid = 3'b001;
    tick();
    set_src(0, 5'd6, 32'h66);
    set_src(1, 5'd4, 32'h44);
    bus.src_valid = 3'b011;
    exp_q.push_back('{idx: 5'd4, data: 32'h44});
    exp_q.push_back('{idx: 5'd6, data: 32'h66});
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL r0_pre_wen got 1 want 0"); end
    tick();
    bus.src_valid = '0;
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL r0_wen got 1 want 0"); end
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      got = '{idx: bus.widx, data: bus.wdata};
      if (bus.wen !== 1'b1 || exp_q.size() == 0 || got !== exp_q[0]) begin
        errors++; $display("[TB] FAIL r0_next_%0d got wen %b idx %0d data %0h want idx %0d", i, bus.wen, bus.widx, bus.wdata, (i == 0) ? 4 : 6);
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_full_rr();
    int       seq [3];
    int       exp_src;
    bit [2:0] acc;
    $display("[TB] test_full_rr");
    do_reset();
    for (int s = 0; s < 3; s++) begin
      seq[s] = 0;
      set_src(s, 5'(10 + s), (32'(s) << 16));
    end
    bus.src_valid = 3'b111;
    bus.hold      = 1'b1;
    for (int c = 0; c < 4; c++) begin
      acc = bus.src_ready & bus.src_valid;
      for (int s = 0; s < 3; s++) if (acc[s]) sq[s].push_back('{idx: bus.src_idx[s], data: bus.src_data[s]});
      tick();
      for (int s = 0; s < 3; s++) if (acc[s]) begin seq[s]++; set_src(s, 5'(10 + s), (32'(s) << 16) | 32'(seq[s])); end
    end
    checks++; if (bus.src_ready !== 3'b000) begin errors++; $display("[TB] FAIL full_ready got %b want 000", bus.src_ready); end
    bus.hold = 1'b0;
    exp_src  = 0;
    for (int c = 0; c < 12; c++) begin
      acc = bus.src_ready & bus.src_valid;
      for (int s = 0; s < 3; s++) if (acc[s]) sq[s].push_back('{idx: bus.src_idx[s], data: bus.src_data[s]});
      tick();
      for (int s = 0; s < 3; s++) if (acc[s]) begin seq[s]++; set_src(s, 5'(10 + s), (32'(s) << 16) | 32'(seq[s])); end
      checks++;
      got = '{idx: bus.widx, data: bus.wdata};
      if (bus.wen !== 1'b1 || sq[exp_src].size() == 0 || got !== sq[exp_src][0]) begin
        errors++; $display("[TB] FAIL full_rr_%0d got wen %b idx %0d data %0h want source %0d", c, bus.wen, bus.widx, bus.wdata, exp_src);
      end
      if (sq[exp_src].size() != 0) void'(sq[exp_src].pop_front());
      exp_src = (exp_src + 1) % 3;
    end
    bus.src_valid = '0;
  endtask

  task automatic test_reset_flush();
    $display("[TB] test_reset_flush");
    do_reset();
    for (int s = 0; s < 3; s++) set_src(s, 5'(9 + s), 32'hF0 + 32'(s));
    bus.src_valid = 3'b111;
    tick();
    bus.src_valid = '0;
    tick();
    checks++; if (bus.wen !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_wen got %b want 1", bus.wen); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL flush_wen got %b want 0", bus.wen); end
    checks++; if (bus.idle !== 1'b1) begin errors++; $display("[TB] FAIL flush_idle got %b want 1", bus.idle); end
    checks++; if (bus.src_ready !== 3'b111) begin errors++; $display("[TB] FAIL flush_ready got %b want 111", bus.src_ready); end
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++; if (bus.wen !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost_%0d got wen 1 idx %0d want 0", c, bus.widx); end
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.src_valid = '0;
    bus.hold      = 1'b0;
    for (int s = 0; s < 3; s++) set_src(s, 5'd0, 32'd0);
    test_reset();
    test_single();
    test_all_sources();
    test_back_to_back();
    test_r0_discard();
    test_full_rr();
    test_reset_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gprf_wb_arb.md
Name: gprf_wb_arb

Overview:
- Writeback arbiter directly upstream of the general-purpose register file (GPRF) write port.
- Collects results from NSRC execution units (ALU, LSU, MUL/DIV), buffers each in a small per-source FIFO, and selects one result per cycle round-robin.
- Drives a single registered write port (wen/widx/wdata) into the GPRF.
- Preserves per-source result order; never drops a result except writes to R0 when R0_IS_0=1.

Parameters:
- NSRC, 3, number of result sources.
- DEPTH, 32, number of GPRF entries.
- WIDTH, 32, data width.
- BUFD, 2, entries per source FIFO (power of 2, >=2).
- R0_IS_0, 1, 1: writes to index 0 are consumed and discarded.
- IW (localparam), $clog2(DEPTH), register index width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- src_valid[0:NSRC-1]  in  1  source result valid.
- src_ready[0:NSRC-1]  out  1  source FIFO can accept.
- src_idx[0:NSRC-1]  in  IW  destination register index.
- src_data[0:NSRC-1]  in  WIDTH  result data.
- hold  in  1  suppress grants this cycle.
- wen  out  1  GPRF write enable.
- widx  out  IW  GPRF write index.
- wdata  out  WIDTH  GPRF write data.
- idle  out  1  all FIFOs empty and wen=0.

Behaviour:
- Reset: all FIFOs empty, rr_ptr=0, wen=0, widx=0, wdata=0.
  - Outputs after the reset edge: src_ready=1 for all sources, idle=1.
  - rst takes priority over every other event; in-flight entries are discarded.
- Handshake:
  - src_ready[s] = (count[s] < BUFD), from registered state only; does not depend on a same-cycle pop.
  - A result is accepted when src_valid & src_ready at posedge.
  - Source may hold src_valid with changing payload while src_ready=0; nothing is captured.
- FIFO:
  - Per-source circular buffer; wrap at BUFD.
  - Simultaneous push and pop on a full FIFO cannot occur (src_ready=0 when full).
  - Simultaneous push and pop on a non-empty, non-full FIFO leaves count unchanged.
- Arbitration (combinational, each cycle):
  - Candidates are sources with count>0.
  - If hold=0 and any candidate exists, grant the first candidate at or after rr_ptr (circular).
  - Pop its head; rr_ptr <= (winner+1) mod NSRC.
  - No grant leaves rr_ptr unchanged.
- Output register, next edge:
  - wen <= grant & ~(R0_IS_0 & head_idx==0).
  - widx/wdata <= head values on grant; otherwise hold previous values.
  - An R0 write still pops and advances rr_ptr.
- Latency:
  - Accept at edge N; head visible after N.
  - Earliest grant in cycle N+1; wen=1 after edge N+1.
  - Minimum 2 cycles accept-to-wen.
- Throughput: 1 write/cycle sustained. With all sources full, each source is served once every NSRC cycles.
- hold=1: no pop, and wen<=0 at the next edge. Pushes still accepted while FIFOs have space.
- Ordering:
  - Same-source order is strict FIFO.
  - Same-index writes from different sources commit in grant order; the later grant wins in the GPRF.
- idle = all count==0 & ~wen.

Decomposition:
- Package gprf_pkg: DEPTH/WIDTH defaults, IW function, and a typedef wb_entry_t {idx[IW], data[WIDTH]}.
- Sub-module wb_fifo (BUFD entries of wb_entry_t; push/pop/count/head ports) instantiated NSRC times.
- Round-robin pick stays in gprf_wb_arb.

Test Plan:
- Reset then single ALU result idx=5 data=0xDEADBEEF accepted at edge N -> wen=1, widx=5, wdata=0xDEADBEEF after edge N+1 only; idle=1 again one cycle later.
- All 3 sources push one result same cycle (idx 1, 2, 3), rr_ptr=0 -> writes in order idx 1, 2, 3 on consecutive cycles; rr_ptr returns to 0.
- Source 1 pushes 3 back-to-back results with BUFD=2 while hold=1 -> src_ready[1]=0 after 2 accepted; the third is held. After hold drops, all 3 commit in order with no loss.
- Source 0 writes idx=0 data=0x1234 with R0_IS_0=1 -> FIFO pops, wen stays 0, rr_ptr advances to 1; the next source-1 result is granted the following cycle.
- All FIFOs kept full for 12 cycles -> grant sequence 0, 1, 2, 0, 1, 2…; wen=1 every cycle; no source starved.
- Assert rst with 2 entries buffered and wen=1 -> after the reset edge wen=0, idle=1, src_ready all 1; the buffered entries never appear on wen.
